// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: line-state enumeration, framing constants and word payload.
package maple_pkg;

    localparam int unsigned START_SLOTS   = 10;
    localparam int unsigned END_SLOTS     = 6;
    localparam int unsigned BITS_PER_WORD = 32;
    localparam int unsigned CRC_BITS      = 8;
    localparam int unsigned SLOT_CNT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_END   = 3'd4
    } maple_state_e;

    typedef struct packed {
        logic [BITS_PER_WORD-1:0] data;
        logic                     last;
    } maple_word_t;

    // XOR of the four bytes of a frame word; the frame checksum accumulates these.
    function automatic logic [CRC_BITS-1:0] byte_xor(input logic [BITS_PER_WORD-1:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/maple_slot_timer.sv
// Slot tick divider: one-cycle tick in the last cycle of every PHASE_TICKS-cycle slot.
module maple_slot_timer #(
    parameter int unsigned PHASE_TICKS = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            tick_d = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tx_maple_bus.sv
// Maple bus frame transmitter: AXI-Stream words in, two-wire SDCKA/SDCKB line sequence out.
module tx_maple_bus
    import maple_pkg::*;
#(
    parameter int unsigned PHASE_TICKS = 25
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        sdcka_o,
    output logic        sdckb_o,
    output logic        sdck_oe,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frames_sent
);

    localparam logic [SLOT_CNT_W-1:0] START_LAST = SLOT_CNT_W'(START_SLOTS - 1);
    localparam logic [SLOT_CNT_W-1:0] DATA_LAST  = SLOT_CNT_W'(2 * BITS_PER_WORD - 1);
    localparam logic [SLOT_CNT_W-1:0] CRC_LAST   = SLOT_CNT_W'(2 * CRC_BITS - 1);
    localparam logic [SLOT_CNT_W-1:0] END_LAST   = SLOT_CNT_W'(END_SLOTS - 1);

    maple_state_e            state_q, state_d;
    logic [SLOT_CNT_W-1:0]   cnt_q, cnt_d;
    maple_word_t             sh_q, sh_d, hold_q, hold_d, in_word;
    logic                    hold_vld_q, hold_vld_d;
    logic [CRC_BITS-1:0]     crc_q, crc_d;
    logic                    aborted_q, aborted_d;
    logic [15:0]             frames_sent_q, frames_sent_d;
    logic                    underrun_q, underrun_d;
    logic                    tready_q, tready_d;
    logic                    busy_q, busy_d;
    logic                    line_a_q, line_a_d, line_b_q, line_b_d, oe_q, oe_d;
    logic                    accept, took_direct, dbit, clk_line, tick;

    assign in_word = '{data: s_axis_tdata, last: s_axis_tlast};
    assign accept  = s_axis_tvalid && tready_q;

    maple_slot_timer #(.PHASE_TICKS(PHASE_TICKS)) u_slot_timer (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .enable (state_q != ST_IDLE),
        .restart(state_q == ST_IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        crc_d         = crc_q;
        aborted_d     = aborted_q;
        frames_sent_d = frames_sent_q;
        underrun_d    = 1'b0;
        took_direct   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    sh_d       = hold_q;
                    hold_vld_d = 1'b0;
                    crc_d      = byte_xor(hold_q.data);
                    state_d    = ST_START;
                    cnt_d      = '0;
                    aborted_d  = 1'b0;
                end else if (accept) begin
                    sh_d        = in_word;
                    took_direct = 1'b1;
                    crc_d       = byte_xor(in_word.data);
                    state_d     = ST_START;
                    cnt_d       = '0;
                    aborted_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    cnt_d   = (cnt_q == START_LAST) ? '0 : cnt_q + SLOT_CNT_W'(1);
                    state_d = (cnt_q == START_LAST) ? ST_DATA : ST_START;
                end
            end
            ST_DATA: begin
                if (tick && cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    // Word boundary: next word follows with no gap slot, else abort the frame.
                    if (sh_q.last) begin
                        state_d = ST_CRC;
                    end else if (hold_vld_q) begin
                        sh_d       = hold_q;
                        hold_vld_d = 1'b0;
                        crc_d      = crc_q ^ byte_xor(hold_q.data);
                    end else if (accept) begin
                        sh_d        = in_word;
                        took_direct = 1'b1;
                        crc_d       = crc_q ^ byte_xor(in_word.data);
                    end else begin
                        state_d    = ST_END;
                        aborted_d  = 1'b1;
                        underrun_d = 1'b1;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + SLOT_CNT_W'(1);
                    if (cnt_q[0]) begin
                        sh_d.data = {sh_q.data[BITS_PER_WORD-2:0], 1'b0};
                    end
                end
            end
            ST_CRC: begin
                if (tick) begin
                    cnt_d   = (cnt_q == CRC_LAST) ? '0 : cnt_q + SLOT_CNT_W'(1);
                    state_d = (cnt_q == CRC_LAST) ? ST_END : ST_CRC;
                    if (cnt_q[0]) begin
                        crc_d = {crc_q[CRC_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_END: begin
                if (tick) begin
                    cnt_d = (cnt_q == END_LAST) ? '0 : cnt_q + SLOT_CNT_W'(1);
                    if (cnt_q == END_LAST) begin
                        state_d = ST_IDLE;
                        if (!aborted_q) begin
                            frames_sent_d = frames_sent_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && !took_direct) begin
            hold_d     = in_word;
            hold_vld_d = 1'b1;
        end

        tready_d = !hold_vld_d && (state_d inside {ST_IDLE, ST_START, ST_DATA});
        busy_d   = (state_d != ST_IDLE);

        // Line values derive from next-state so the registered lines align with state_q.
        line_a_d = 1'b1;
        line_b_d = 1'b1;
        oe_d     = 1'b0;
        dbit     = (state_d == ST_DATA) ? sh_d.data[BITS_PER_WORD-1] : crc_d[CRC_BITS-1];
        clk_line = ~cnt_d[0];
        unique case (state_d)
            ST_START: begin
                oe_d = 1'b1;
                if (cnt_d == '0) begin
                    line_a_d = 1'b0;
                end else if (cnt_d != START_LAST) begin
                    line_a_d = 1'b0;
                    line_b_d = ~cnt_d[0];
                end
            end
            ST_DATA, ST_CRC: begin
                oe_d     = 1'b1;
                line_a_d = cnt_d[1] ? dbit : clk_line;
                line_b_d = cnt_d[1] ? clk_line : dbit;
            end
            ST_END: begin
                oe_d = 1'b1;
                if (cnt_d == '0) begin
                    line_b_d = 1'b0;
                end else if (cnt_d != END_LAST) begin
                    line_a_d = ~cnt_d[0];
                    line_b_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sh_q          <= '0;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            crc_q         <= '0;
            aborted_q     <= 1'b0;
            frames_sent_q <= '0;
            underrun_q    <= 1'b0;
            tready_q      <= 1'b0;
            busy_q        <= 1'b0;
            line_a_q      <= 1'b1;
            line_b_q      <= 1'b1;
            oe_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            crc_q         <= crc_d;
            aborted_q     <= aborted_d;
            frames_sent_q <= frames_sent_d;
            underrun_q    <= underrun_d;
            tready_q      <= tready_d;
            busy_q        <= busy_d;
            line_a_q      <= line_a_d;
            line_b_q      <= line_b_d;
            oe_q          <= oe_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign sdcka_o       = line_a_q;
    assign sdckb_o       = line_b_q;
    assign sdck_oe       = oe_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;
    assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_tx_maple_bus.sv
// Bench for tx_maple_bus: slot-level line model, line decoder and frame counter model.
module tb_tx_maple_bus;

    localparam int unsigned PT = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        sdcka_o, sdckb_o, sdck_oe, busy, underrun;
    logic [15:0] frames_sent;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  trace[$];
    int          ur_cycles = 0;
    logic [15:0] exp_frames;
    logic [1:0]  exp_slots[$];
    logic [31:0] dec_words[$];
    logic [7:0]  dec_crc;
    bit          dec_ok;

    tx_maple_bus #(.PHASE_TICKS(PT)) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .sdcka_o      (sdcka_o),
        .sdckb_o      (sdckb_o),
        .sdck_oe      (sdck_oe),
        .busy         (busy),
        .underrun     (underrun),
        .frames_sent  (frames_sent)
    );

    always #5 ACLK = ~ACLK;

    // Per-cycle record of driven line pairs {A,B} and count of underrun-high cycles.
    always @(negedge ACLK) begin
        if (sdck_oe === 1'b1) trace.push_back({sdcka_o, sdckb_o});
        if (underrun === 1'b1) ur_cycles++;
    end

    function automatic logic [7:0] model_crc(input logic [31:0] w[$]);
        logic [7:0] c = 8'h00;
        foreach (w[i]) for (int k = 0; k < 4; k++) c ^= 8'(w[i] >> (8 * k));
        return c;
    endfunction

    task automatic add_bit(input int n, input logic b);
        if (n % 2 == 0) begin
            exp_slots.push_back({1'b1, b});
            exp_slots.push_back({1'b0, b});
        end else begin
            exp_slots.push_back({b, 1'b1});
            exp_slots.push_back({b, 1'b0});
        end
    endtask

    task automatic build_expected(input logic [31:0] w[$], input bit abort);
        int n = 0;
        logic [7:0] c;
        exp_slots.delete();
        exp_slots.push_back(2'b01);
        for (int k = 0; k < 8; k++) exp_slots.push_back({1'b0, 1'(k % 2)});
        exp_slots.push_back(2'b11);
        foreach (w[i]) for (int b = 31; b >= 0; b--) begin add_bit(n, w[i][b]); n++; end
        if (!abort) begin
            c = model_crc(w);
            for (int b = 7; b >= 0; b--) begin add_bit(n, c[b]); n++; end
        end
        exp_slots.push_back(2'b10);
        for (int k = 0; k < 4; k++) exp_slots.push_back({1'(k % 2), 1'b0});
        exp_slots.push_back(2'b11);
    endtask

    // Receiver view: sample the data line on each falling edge of the alternating clock line.
    task automatic decode(input int base, input int nwords, input bit with_crc);
        int idx = base + 10 * PT;
        int nbits = 32 * nwords + (with_crc ? 8 : 0);
        logic [31:0] acc = '0;
        bit found;
        logic d;
        dec_words.delete();
        dec_crc = 8'h00;
        dec_ok = 1'b1;
        for (int n = 0; n < nbits && dec_ok; n++) begin
            found = 1'b0;
            d = 1'b0;
            for (int j = idx; j < trace.size() && !found; j++) begin
                if (n % 2 == 0 && trace[j-1][1] && !trace[j][1]) begin
                    found = 1'b1; d = trace[j][0]; idx = j + 1;
                end else if (n % 2 == 1 && trace[j-1][0] && !trace[j][0]) begin
                    found = 1'b1; d = trace[j][1]; idx = j + 1;
                end
            end
            if (!found) dec_ok = 1'b0;
            acc = {acc[30:0], d};
            if (n < 32 * nwords && n % 32 == 31) dec_words.push_back(acc);
            if (n >= 32 * nwords) dec_crc = {dec_crc[6:0], d};
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic last, input string name);
        bit acc = 1'b0;
        bit rdy;
        s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        for (int c = 0; c < 3000 && !acc; c++) begin
            rdy = s_axis_tready;
            @(posedge ACLK);
            if (rdy) acc = 1'b1;
            @(negedge ACLK);
        end
        n_checks++;
        if (!acc) begin
            n_errors++;
            $display("FAIL %s accept: word %h not accepted, required acceptance", name, d);
        end
    endtask

    task automatic do_frame(input string name, input logic [31:0] w[$], input bit last_tlast,
                            input int gap_max, input int crc_const);
        int base = trace.size();
        int ur0 = ur_cycles;
        bit abort = !last_tlast;
        int limit = (10 + 64 * w.size() + 16 + 6) * PT + 50;
        int bad = -1;
        foreach (w[i]) begin
            if (i > 0 && gap_max > 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge ACLK);
            end
            push_word(w[i], (i == w.size() - 1) ? last_tlast : 1'b0, name);
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        for (int c = 0; c < limit && busy === 1'b1; c++) @(negedge ACLK);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL %s done: busy=%b after %0d cycles, required 0", name, busy, limit);
        end
        n_checks++;
        if ({sdck_oe, sdcka_o, sdckb_o} !== 3'b011) begin
            n_errors++; $display("FAIL %s release: oe,A,B=%b required 011", name, {sdck_oe, sdcka_o, sdckb_o});
        end
        build_expected(w, abort);
        n_checks++;
        if (trace.size() - base != exp_slots.size() * PT) begin
            n_errors++;
            $display("FAIL %s length: %0d driven cycles, required %0d", name, trace.size() - base, exp_slots.size() * PT);
        end else begin
            for (int j = 0; j < exp_slots.size() * int'(PT) && bad < 0; j++)
                if (trace[base + j] !== exp_slots[j / PT]) bad = j;
            n_checks++;
            if (bad >= 0) begin
                n_errors++;
                $display("FAIL %s lines: cycle %0d (slot %0d) AB=%b required %b", name, bad, bad / PT,
                         trace[base + bad], exp_slots[bad / PT]);
            end
        end
        decode(base, w.size(), !abort);
        n_checks++;
        if (!dec_ok || dec_words != w) begin
            n_errors++;
            $display("FAIL %s decode: ok=%b got %0d words first %h, required %0d words first %h",
                     name, dec_ok, dec_words.size(), (dec_words.size() > 0) ? dec_words[0] : 32'h0, w.size(), w[0]);
        end
        if (!abort) begin
            n_checks++;
            if (dec_crc !== model_crc(w) || (crc_const >= 0 && dec_crc !== 8'(crc_const))) begin
                n_errors++; $display("FAIL %s crc: got %h required %h", name, dec_crc, model_crc(w));
            end
            exp_frames = exp_frames + 16'd1;
        end
        n_checks++;
        if (ur_cycles - ur0 != (abort ? 1 : 0)) begin
            n_errors++; $display("FAIL %s underrun: %0d high cycles, required %0d", name, ur_cycles - ur0, abort ? 1 : 0);
        end
        n_checks++;
        if (frames_sent !== exp_frames) begin
            n_errors++; $display("FAIL %s frames_sent: got %h required %h", name, frames_sent, exp_frames);
        end
        repeat (3) @(negedge ACLK);
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if ({s_axis_tready, sdck_oe, sdcka_o, sdckb_o, busy, underrun} !== 6'b001100 || frames_sent !== 16'h0) begin
            n_errors++;
            $display("FAIL reset values: rdy,oe,A,B,busy,ur=%b frames=%h required 001100 0000",
                     {s_axis_tready, sdck_oe, sdcka_o, sdckb_o, busy, underrun}, frames_sent);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_errors++; $display("FAIL reset tready_rise: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_single_word;
        logic [31:0] w[$];
        w.push_back(32'h80000001);
        do_frame("single_word", w, 1'b1, 0, 'h81);
    endtask

    task automatic test_back_to_back;
        logic [31:0] w[$];
        w.push_back(32'h01020304); w.push_back(32'h05060708); w.push_back(32'h0A0B0C0D);
        do_frame("back_to_back", w, 1'b1, 0, 'h08);
    endtask

    task automatic test_underrun;
        logic [31:0] w[$];
        w.push_back($urandom);
        do_frame("underrun", w, 1'b0, 0, -1);
    endtask

    task automatic test_random;
        logic [31:0] w[$];
        for (int f = 0; f < 5; f++) begin
            w.delete();
            repeat ($urandom_range(1, 3)) w.push_back($urandom);
            do_frame($sformatf("random%0d", f), w, 1'b1, 12, -1);
        end
    endtask

    task automatic test_reset_mid_frame;
        int tr0;
        int ur0;
        push_word($urandom, 1'b1, "mid_reset");
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (30 * PT + 1) @(negedge ACLK);
        n_checks++;
        if ({busy, sdck_oe} !== 2'b11) begin
            n_errors++; $display("FAIL mid_reset active: busy,oe=%b required 11", {busy, sdck_oe});
        end
        ur0 = ur_cycles;
        ARESETN = 1'b0;
        @(negedge ACLK);
        tr0 = trace.size();
        n_checks++;
        if ({sdck_oe, sdcka_o, sdckb_o, busy, underrun, s_axis_tready} !== 6'b011000) begin
            n_errors++;
            $display("FAIL mid_reset release: oe,A,B,busy,ur,rdy=%b required 011000",
                     {sdck_oe, sdcka_o, sdckb_o, busy, underrun, s_axis_tready});
        end
        exp_frames = 16'h0000;
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_errors++; $display("FAIL mid_reset tready: got %b required 1", s_axis_tready);
        end
        repeat (20 * PT) @(negedge ACLK);
        n_checks++;
        if (trace.size() != tr0 || ur_cycles != ur0 || frames_sent !== exp_frames) begin
            n_errors++;
            $display("FAIL mid_reset quiet: %0d driven cycles, %0d underrun cycles, frames %h; required 0 0 %h",
                     trace.size() - tr0, ur_cycles - ur0, frames_sent, exp_frames);
        end
    endtask

    task automatic test_frame_counter_wrap;
        logic [31:0] w[$];
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge ACLK);
        release dut.frames_sent_q;
        @(negedge ACLK);
        exp_frames = 16'hFFFF;
        w.push_back($urandom);
        do_frame("counter_wrap", w, 1'b1, 0, -1);
        n_checks++;
        if (frames_sent !== 16'h0000) begin
            n_errors++; $display("FAIL counter_wrap value: got %h required 0000", frames_sent);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        exp_frames = 16'h0000;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_random();
        test_reset_mid_frame();
        test_frame_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_maple_bus.md
TX_MAPLE_BUS -- requirements
Module: tx_maple_bus

Interface
REQ-001 SHALL have parameter PHASE_TICKS, default 25, meaning ACLK cycles per line slot (250 ns at 100 MHz); legal range 2..1023.
REQ-002 SHALL have port ACLK  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port ARESETN  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port s_axis_tdata  in  32  frame word; bit 31 is transmitted first.
REQ-005 SHALL have port s_axis_tvalid  in  1  word valid.
REQ-006 SHALL have port s_axis_tready  out  1  word accepted on tvalid&tready.
REQ-007 SHALL have port s_axis_tlast  in  1  marks last word of a frame.
REQ-008 SHALL have ports sdcka_o, sdckb_o  out  1 each  Maple line drive values.
REQ-009 SHALL have port sdck_oe  out  1  high drives both lines; low releases them (external pull-up).
REQ-010 SHALL have port busy  out  1  high in any state except IDLE.
REQ-011 SHALL have port underrun  out  1  one-cycle pulse on frame abort.
REQ-012 SHALL have port frames_sent  out  16  count of frames completed with checksum; wraps 0xFFFF->0x0000.

Function
REQ-013 SHALL time all line changes on a slot tick every PHASE_TICKS cycles; the tick counter restarts at 0 on leaving IDLE.
REQ-014 SHALL implement states IDLE, START, DATA, CRC, END.
REQ-015 IDLE: sdck_oe=0, sdcka_o=sdckb_o=1; on an accepted word, move to START on the next cycle.
REQ-016 START: 10 slots; (A,B) = (0,1), then B = 0,1,0,1,0,1,0,1 with A=0, then (1,1); then DATA.
REQ-017 DATA: each bit occupies 2 slots; bits with even index n (0 = first bit of frame) use A as clock and B as data; odd n use B as clock and A as data.
REQ-018 Per bit: slot 0 clock line=1, data line=bit; slot 1 clock line=0, data line held; receiver samples on the clock falling edge.
REQ-019 SHALL hold a current-word shift register plus one holding register; s_axis_tready=1 exactly when the holding register is empty and state is not CRC/END.
REQ-020 At the end of the 32nd bit: if the current word had tlast, go to CRC; else if holding register full, load it with no gap slot; else abort.
REQ-021 Abort: go directly to END (checksum skipped), pulse underrun, frames_sent unchanged.
REQ-022 Checksum = XOR of all 4*N frame bytes; sent in CRC as 8 bits, MSB first, continuing bit-index parity from DATA.
REQ-023 END: 6 slots; (A,B) = (1,0), then A = 0,1,0,1 with B=0, then (1,1); then IDLE, and increment frames_sent if not aborted.
REQ-024 sdck_oe SHALL be 1 from the first START slot through the last END slot inclusive.
REQ-025 A word accepted while in END SHALL NOT be possible (tready=0); new frame begins only from IDLE.
REQ-026 Simultaneous load of holding register and transfer to shift register in one cycle SHALL keep the new word, not drop it.

Reset
REQ-027 While ARESETN=0 at a rising ACLK edge: state=IDLE, s_axis_tready=0, sdck_oe=0, sdcka_o=sdckb_o=1, busy=0, underrun=0, frames_sent=0, holding register empty, checksum=0.
REQ-028 tready SHALL rise the first cycle after ARESETN returns high.
REQ-029 Reset mid-frame SHALL release lines immediately without generating END; no underrun pulse.

Structure
REQ-030 SHALL place the state enumeration, START_SLOTS=10, END_SLOTS=6, BITS_PER_WORD=32, CRC_BITS=8 in shared package maple_pkg, also used by the receiver.
REQ-031 SHALL implement the slot-tick divider as sub-module maple_slot_timer (inputs: enable, restart; output: tick).

Verification
REQ-032 PHASE_TICKS=4, one word 0x80000001 with tlast -> 10 START slots, 64 DATA slots with first bit 1 on B, CRC byte 0x81, 6 END slots, frames_sent=1.
REQ-033 Back-to-back 3-word frame 0x01020304, 0x05060708, 0x0A0B0C0D(tlast) with tvalid constant -> no gap between words, CRC 0x08, underrun never pulses.
REQ-034 2-word frame, tvalid dropped after first word (no tlast) -> END immediately after bit 31, underrun one cycle, frames_sent unchanged, lines released after END.
REQ-035 ARESETN low for one cycle during bit 10 of DATA -> next cycle sdck_oe=0, A=B=1, state IDLE; tready=1 after release.
REQ-036 frames_sent preset by sending 65536 one-word frames (PHASE_TICKS=2) -> counter reads 0x0000.
REQ-037 Decoder checker on sdcka_o/sdckb_o SHALL reconstruct every sent word exactly in all above scenarios.
